// File: rtl/nco_doppler_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nco_doppler_ctrl_pkg
// Shared definitions for the Doppler search controller, the NCO and the loop
// filter.
//   - state_e  : controller FSM encoding (IDLE/LOAD/DWELL/TRACK)
//   - FCW_W    : NCO frequency control word width
//   - ERR_W    : loop-filter phase correction width
//   - ENERGY_W : correlator energy sample width
//   - ACC_W    : integrated energy width
//   - BIN_W    : Doppler bin index width
//   - sat_add  : saturating energy accumulate
//   - bin_fcw  : frequency control word of a given bin
// -----------------------------------------------------------------------------
package nco_doppler_ctrl_pkg;

   localparam int FCW_W    = 34;
   localparam int ERR_W    = 17;
   localparam int ENERGY_W = 24;
   localparam int ACC_W    = 34;
   localparam int BIN_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DWELL = 2'd2,
      ST_TRACK = 2'd3
   } state_e;

   // Adds one energy sample and clamps at the all-ones value instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0]    acc,
                                                input logic [ENERGY_W-1:0] sample);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {{(ACC_W-ENERGY_W+1){1'b0}}, sample};
      if (sum[ACC_W]) begin
         sat_add = {ACC_W{1'b1}};
      end else begin
         sat_add = sum[ACC_W-1:0];
      end
   endfunction

   // base + bin*step, modulo 2^FCW_W.
   function automatic logic [FCW_W-1:0] bin_fcw(input logic [FCW_W-1:0] base,
                                                input logic [FCW_W-1:0] step,
                                                input logic [BIN_W-1:0] bin);
      bin_fcw = base + step * {{(FCW_W-BIN_W){1'b0}}, bin};
   endfunction

endpackage

// File: rtl/nco_doppler_ctrl_energy_integrator.sv
// -----------------------------------------------------------------------------
// nco_doppler_ctrl_energy_integrator
// Saturating energy accumulator plus sample counter for one Doppler bin.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clr            : synchronous clear of accumulator and counter
//   en             : integration window open
//   sample_valid   : qualifies sample
//   sample         : unsigned correlator energy
//   acc_sum        : accumulator including the current sample (combinational)
//   dwell_done     : the DWELL-th sample is being accepted this cycle
// -----------------------------------------------------------------------------
module nco_doppler_ctrl_energy_integrator
   import nco_doppler_ctrl_pkg::*;
#(
   parameter int DWELL = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic                sample_valid,
   input  logic [ENERGY_W-1:0] sample,
   output logic [ACC_W-1:0]    acc_sum,
   output logic                dwell_done
);

   localparam int CNT_W = $clog2(DWELL + 1);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next-state and strobe logic; acc_sum is presented before the flop so the
   // bin decision can use the final sample in the same cycle.
   always_comb begin
      acc_sum    = sat_add(acc_q, sample);
      dwell_done = en && sample_valid && (cnt_q == CNT_W'(DWELL - 1));
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      if (clr) begin
         acc_d = {ACC_W{1'b0}};
         cnt_d = {CNT_W{1'b0}};
      end else if (en && sample_valid) begin
         acc_d = acc_sum;
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end
   end

   // Accumulator and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= {ACC_W{1'b0}};
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nco_doppler_ctrl.sv
// -----------------------------------------------------------------------------
// nco_doppler_ctrl
// Doppler bin sweep controller for an NCO: steps the NCO through NBINS
// frequency bins, integrates correlator energy for DWELL samples per bin,
// retunes to the strongest bin if it clears the threshold, then forwards
// loop-filter corrections while tracking.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   start, abort           : begin sweep (from IDLE only) / return to IDLE
//   fcw_base, fcw_step     : FCW of bin 0 and per-bin FCW increment
//   corr_valid/corr_energy : correlator energy samples
//   threshold              : minimum integrated energy for acquisition
//   loop_valid/loop_err    : loop-filter phase correction
//   lock_lost              : lock detector level, restarts sweep from TRACK
//   phase_increment        : NCO frequency control word
//   phase_error            : NCO per-cycle phase correction
//   nco_load               : one-cycle pulse when phase_increment changes
//   state                  : FSM state
//   locked, done, fail     : acquisition status
//   best_bin               : winning bin index
// -----------------------------------------------------------------------------
module nco_doppler_ctrl
   import nco_doppler_ctrl_pkg::*;
#(
   parameter int NBINS = 16,
   parameter int DWELL = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [FCW_W-1:0]    fcw_base,
   input  logic [FCW_W-1:0]    fcw_step,
   input  logic                corr_valid,
   input  logic [ENERGY_W-1:0] corr_energy,
   input  logic [ACC_W-1:0]    threshold,
   input  logic                loop_valid,
   input  logic [ERR_W-1:0]    loop_err,
   input  logic                lock_lost,
   output logic [FCW_W-1:0]    phase_increment,
   output logic [ERR_W-1:0]    phase_error,
   output logic                nco_load,
   output logic [1:0]          state,
   output logic                locked,
   output logic                done,
   output logic                fail,
   output logic [BIN_W-1:0]    best_bin
);

   state_e           state_q,       state_d;
   logic [BIN_W-1:0] bin_q,         bin_d;
   logic [ACC_W-1:0] best_energy_q, best_energy_d;
   logic [BIN_W-1:0] best_bin_q,    best_bin_d;
   logic [FCW_W-1:0] phase_inc_q,   phase_inc_d;
   logic [ERR_W-1:0] phase_err_q,   phase_err_d;
   logic             nco_load_q,    nco_load_d;
   logic             locked_q,      locked_d;
   logic             done_q,        done_d;
   logic             fail_q,        fail_d;

   logic [ACC_W-1:0] acc_sum_s;
   logic             dwell_done_s;
   logic             new_best_s;
   logic [ACC_W-1:0] win_energy_s;
   logic [BIN_W-1:0] win_bin_s;

   nco_doppler_ctrl_energy_integrator #(
      .DWELL (DWELL)
   ) u_energy_integrator (
      .clk          (clk),
      .rst          (rst),
      .clr          (state_q == ST_LOAD),
      .en           (state_q == ST_DWELL),
      .sample_valid (corr_valid),
      .sample       (corr_energy),
      .acc_sum      (acc_sum_s),
      .dwell_done   (dwell_done_s)
   );

   // Next-state logic for the sweep/track FSM and all registered outputs.
   always_comb begin
      state_d       = state_q;
      bin_d         = bin_q;
      best_energy_d = best_energy_q;
      best_bin_d    = best_bin_q;
      phase_inc_d   = phase_inc_q;
      phase_err_d   = {ERR_W{1'b0}};
      nco_load_d    = 1'b0;
      locked_d      = locked_q;
      done_d        = 1'b0;
      fail_d        = 1'b0;

      // Strictly greater wins, so on a tie the earlier (lower) bin is kept.
      new_best_s   = dwell_done_s && (acc_sum_s > best_energy_q);
      win_energy_s = new_best_s ? acc_sum_s : best_energy_q;
      win_bin_s    = new_best_s ? bin_q : best_bin_q;

      if (abort) begin
         // Abort outranks start, lock_lost and bin completion; FCW is held.
         state_d  = ST_IDLE;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bin_d         = {BIN_W{1'b0}};
                  best_energy_d = {ACC_W{1'b0}};
                  best_bin_d    = {BIN_W{1'b0}};
                  state_d       = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               phase_inc_d = bin_fcw(fcw_base, fcw_step, bin_q);
               nco_load_d  = 1'b1;
               state_d     = ST_DWELL;
            end
            ST_DWELL: begin
               if (dwell_done_s) begin
                  best_energy_d = win_energy_s;
                  best_bin_d    = win_bin_s;
                  if (bin_q != BIN_W'(NBINS - 1)) begin
                     bin_d   = bin_q + 8'd1;
                     state_d = ST_LOAD;
                  end else if (win_energy_s >= threshold) begin
                     phase_inc_d = bin_fcw(fcw_base, fcw_step, win_bin_s);
                     nco_load_d  = 1'b1;
                     locked_d    = 1'b1;
                     done_d      = 1'b1;
                     state_d     = ST_TRACK;
                  end else begin
                     done_d   = 1'b1;
                     fail_d   = 1'b1;
                     locked_d = 1'b0;
                     state_d  = ST_IDLE;
                  end
               end else begin
                  state_d = ST_DWELL;
               end
            end
            ST_TRACK: begin
               if (lock_lost) begin
                  // Fresh sweep from bin 0; previous winner is forgotten.
                  locked_d      = 1'b0;
                  bin_d         = {BIN_W{1'b0}};
                  best_energy_d = {ACC_W{1'b0}};
                  best_bin_d    = {BIN_W{1'b0}};
                  state_d       = ST_LOAD;
               end else if (loop_valid) begin
                  phase_err_d = loop_err;
               end else begin
                  phase_err_d = {ERR_W{1'b0}};
               end
            end
            default: begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bin_q         <= {BIN_W{1'b0}};
         best_energy_q <= {ACC_W{1'b0}};
         best_bin_q    <= {BIN_W{1'b0}};
         phase_inc_q   <= {FCW_W{1'b0}};
         phase_err_q   <= {ERR_W{1'b0}};
         nco_load_q    <= 1'b0;
         locked_q      <= 1'b0;
         done_q        <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bin_q         <= bin_d;
         best_energy_q <= best_energy_d;
         best_bin_q    <= best_bin_d;
         phase_inc_q   <= phase_inc_d;
         phase_err_q   <= phase_err_d;
         nco_load_q    <= nco_load_d;
         locked_q      <= locked_d;
         done_q        <= done_d;
         fail_q        <= fail_d;
      end
   end

   assign state           = state_q;
   assign phase_increment = phase_inc_q;
   assign phase_error     = phase_err_q;
   assign nco_load        = nco_load_q;
   assign locked          = locked_q;
   assign done            = done_q;
   assign fail            = fail_q;
   assign best_bin        = best_bin_q;

endmodule
